// File: rtl/lvc_ahb_pkg.sv
// Shared AHB-Lite encodings plus the memory slave's FSM state type.
// Also holds the byte-lane strobe helper.
package lvc_ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'd0,
    HRESP_ERROR = 2'd1,
    HRESP_RETRY = 2'd2,
    HRESP_SPLIT = 2'd3
  } hresp_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  typedef enum logic [1:0] {
    SLV_IDLE = 2'd0,
    SLV_WAIT = 2'd1,
    SLV_ERR1 = 2'd2,
    SLV_ERR2 = 2'd3
  } slv_state_e;

  // Little-endian lane enables for an already-validated size/offset pair.
  function automatic logic [3:0] byte_strobe(input logic [2:0] size, input logic [1:0] lo);
    logic [3:0] strb;
    case (size)
      HSIZE_BYTE: strb = 4'b0001 << lo;
      HSIZE_HALF: strb = lo[1] ? 4'b1100 : 4'b0011;
      default:    strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/lvc_ahb_slave_mem_ram.sv
// Word-organised storage with per-byte write enables and asynchronous read.
// Contents are deliberately never reset.
module lvc_ahb_slave_mem_ram #(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic [3:0]       we,
  input  logic [IDX_W-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/lvc_ahb_slave_mem.sv
// AHB-Lite memory slave: address decode, wait-state/error FSM and data-phase control.
// Storage lives in lvc_ahb_slave_mem_ram.
module lvc_ahb_slave_mem
  import lvc_ahb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready_in,
  output logic                  hready,
  output logic [1:0]            hresp,
  output logic [DATA_WIDTH-1:0] hrdata
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  slv_state_e       state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic             write_q, write_d;
  logic [IDX_W-1:0] addr_q, addr_d;
  logic [3:0]       strb_q, strb_d;

  logic             accept, bad_xfer, size_bad, misaligned, out_of_range, take;
  logic [3:0]       ram_we;
  logic [31:0]      ram_rdata;
  logic             unused_ok;

  assign unused_ok = &{1'b0, hburst, hprot, haddr};

  always_comb begin
    accept       = hsel & hready_in & (htrans_e'(htrans) inside {HTRANS_NONSEQ, HTRANS_SEQ});
    size_bad     = hsize > HSIZE_WORD;
    misaligned   = ((hsize == HSIZE_HALF) && haddr[0]) ||
                   ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00));
    out_of_range = (haddr >> 2) >= ADDR_WIDTH'(MEM_DEPTH);
    bad_xfer     = size_bad | misaligned | out_of_range;
  end

  // ERR2 completes its data phase like IDLE, so both may take a new address phase.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    write_d = write_q;
    addr_d  = addr_q;
    strb_d  = strb_q;
    hready  = 1'b1;
    hresp   = HRESP_OKAY;
    take    = 1'b0;

    case (state_q)
      SLV_IDLE: take = 1'b1;
      SLV_WAIT: begin
        hready = 1'b0;
        cnt_d  = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) begin
          state_d = SLV_IDLE;
          cnt_d   = 3'd0;
        end
      end
      SLV_ERR1: begin
        hready  = 1'b0;
        hresp   = HRESP_ERROR;
        state_d = SLV_ERR2;
      end
      SLV_ERR2: begin
        hresp   = HRESP_ERROR;
        state_d = SLV_IDLE;
        take    = 1'b1;
      end
      default: state_d = SLV_IDLE;
    endcase

    if (take) begin
      phase_d = 1'b0;
      if (accept) begin
        if (bad_xfer) begin
          state_d = SLV_ERR1;
        end else begin
          phase_d = 1'b1;
          write_d = hwrite;
          addr_d  = haddr[IDX_W+1:2];
          strb_d  = byte_strobe(hsize, haddr[1:0]);
          if (WAIT_STATES > 0) begin
            state_d = SLV_WAIT;
            cnt_d   = 3'(WAIT_STATES);
          end else begin
            state_d = SLV_IDLE;
          end
        end
      end
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q <= SLV_IDLE;
      cnt_q   <= 3'd0;
      phase_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      strb_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      strb_q  <= strb_d;
    end
  end

  // Only the ready cycle of a good write phase commits; wait cycles and error phases never do.
  assign ram_we = (state_q == SLV_IDLE && phase_q && write_q) ? strb_q : 4'd0;
  assign hrdata = (phase_q && !write_q) ? ram_rdata : '0;

  lvc_ahb_slave_mem_ram #(
    .DEPTH (MEM_DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk   (hclk),
    .we    (ram_we),
    .addr  (addr_q),
    .wdata (hwdata),
    .rdata (ram_rdata)
  );

endmodule

// File: doc/lvc_ahb_slave_mem.md
LVC_AHB_SLAVE_MEM -- requirements
Module: lvc_ahb_slave_mem

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, haddr width.
REQ-002 Parameter DATA_WIDTH, default 32, hwdata/hrdata width; only 32 is supported.
REQ-003 Parameter MEM_DEPTH, default 256, number of 32-bit words.
REQ-004 Parameter WAIT_STATES, default 0, range 0..7, inserted wait cycles per OKAY data phase.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows:
- hclk  in  1  clock; all state updates on rising edge.
- hreset  in  1  asynchronous, active-high reset.
- hsel  in  1  slave select.
- haddr  in  ADDR_WIDTH  address-phase byte address.
- htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- hwrite  in  1  1=write.
- hsize  in  3  0=byte, 1=half, 2=word.
- hburst  in  3  burst type; ignored functionally.
- hprot  in  4  protection; ignored.
- hwdata  in  DATA_WIDTH  write data, valid in data phase.
- hready_in  in  1  bus-level hready.
- hready  out  1  slave ready for the current data phase.
- hresp  out  2  OKAY=0, ERROR=1; RETRY/SPLIT never driven.
- hrdata  out  DATA_WIDTH  read data.

Function
REQ-006 A transfer SHALL be accepted on a rising edge where hsel=1, hready_in=1 and htrans[1]=1; haddr, hwrite and hsize SHALL then be latched.
REQ-007 IDLE/BUSY, or hsel=0, SHALL produce a zero-wait OKAY data phase with no memory access.
REQ-008 A transfer SHALL be erroneous if haddr[ADDR_WIDTH-1:2] >= MEM_DEPTH, if hsize > 2, or if haddr is not aligned to hsize.
REQ-009 FSM states: IDLE, WAIT, ERR1, ERR2.
REQ-010 IDLE: hready=1, hresp=OKAY. On accepting an erroneous transfer, go to ERR1. On accepting a good transfer with WAIT_STATES>0, go to WAIT with the counter loaded to WAIT_STATES. On accepting a good transfer with WAIT_STATES=0, stay in IDLE (data phase completes next cycle).
REQ-011 WAIT: hready=0, hresp=OKAY; decrement the counter each cycle; at 1, return to IDLE. The data phase SHALL last exactly WAIT_STATES+1 cycles.
REQ-012 ERR1: hready=0, hresp=ERROR, then unconditionally go to ERR2.
REQ-013 ERR2: hready=1, hresp=ERROR. Any transfer accepted in this cycle SHALL be handled per REQ-010, leaving ERR2 exactly as IDLE would.
REQ-014 Write commit SHALL occur on the completing cycle of a good write data phase (hready=1), using hwdata and the byte lanes selected by latched hsize/haddr[1:0], little-endian.
REQ-015 Erroneous writes SHALL NOT modify memory.
REQ-016 During a good read data phase, hrdata SHALL equal the full word mem[latched addr word]; otherwise hrdata SHALL be 0.
REQ-017 Accepted transfers are back-to-back pipelined: an address phase accepted on a data-phase completion edge SHALL start the next data phase with no bubble.
REQ-018 A read data phase SHALL return data that includes a write committed on the immediately preceding completion edge.

Reset
REQ-019 Assertion of hreset at any time, including mid-data-phase, SHALL immediately force: FSM=IDLE, counter=0, hready=1, hresp=OKAY, hrdata=0, and clear the latched transfer.
REQ-020 Memory contents SHALL NOT be reset; a write pending at reset assertion SHALL be dropped.

Structure
REQ-021 htrans, hresp and hsize encodings SHALL reuse the shared lvc_ahb_pkg enums; the FSM state enum SHALL also be added to lvc_ahb_pkg.
REQ-022 The storage array with byte-lane write enables SHALL be a sub-module named lvc_ahb_slave_mem_ram; FSM and decode SHALL stay in the top module.

Verification
REQ-023 With WAIT_STATES=0: write word 0xDEADBEEF to 0x10, then read 0x10 back to back -> hready stays 1, hrdata=0xDEADBEEF, hresp=OKAY.
REQ-024 With WAIT_STATES=3: read 0x10 -> hready low for exactly 3 cycles, high on the 4th with the data.
REQ-025 Byte write 0xAA to 0x13 over 0x11223344, then read the word -> 0xAA223344.
REQ-026 Access 0x400 with MEM_DEPTH=256, or a half-word at 0x01 -> ERR1 (hready=0, ERROR) then ERR2 (hready=1, ERROR); memory unchanged.
REQ-027 Assert hreset during the 2nd wait cycle of a write -> hready=1, hresp=OKAY, hrdata=0 immediately; target word unchanged.
REQ-028 NONSEQ, BUSY, SEQ sequence -> the BUSY cycle gives a zero-wait OKAY with no access; the SEQ transfer completes normally.
